spi_cmd_master: RTL and testbench

- Upstream SPI master that serialises one processor command (4-bit opcode, 32-bit operand A, 32-bit operand B) to the SPI execution slaves (shifter, ALU).
- Receives the slave's 32-bit result on MISO and returns it to the core through a valid/ready response port.
- One transaction per nss-low frame; the timing is matched exactly to the slaves' level-sampled SCLK protocol.

---
 rtl/spi_proc_pkg.sv | 36 +++
 rtl/spi_if.sv | 18 +
 rtl/spi_phase_timer.sv | 43 ++++
 rtl/spi_cmd_master.sv | 167 ++++++++++++++++
 tb/tb_spi_cmd_master.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_proc_pkg.sv
// ============================================================================
// Package  : spi_proc_pkg
// Shared opcodes, frame geometry and master FSM state type for the SPI slaves.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spi_proc_pkg;

  localparam int OPCODE_W          = 4;
  localparam int FRAME_BITS        = 68;
  localparam int TURNAROUND_CYCLES = 2;

  localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_AND = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_OR  = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_XOR = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_SLT = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_SHL = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_SHR = 4'b0111;
  localparam logic [OPCODE_W-1:0] OP_SAR = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX_LOW  = 3'd1,
    ST_TX_HIGH = 3'd2,
    ST_TURN    = 3'd3,
    ST_RX_LOW  = 3'd4,
    ST_RX_HIGH = 3'd5,
    ST_RESP    = 3'd6
  } spi_master_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_if.sv
// ============================================================================
// Interface : spi_if
// Four-wire SPI bus between the command master and an execution slave.
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface spi_if;
  logic nss;
  logic sclk;
  logic mosi;
  logic miso;

  modport MASTER (output nss, output sclk, output mosi, input miso);
  modport SLAVE  (input nss, input sclk, input mosi, output miso);
endinterface

`default_nettype wire

// File: rtl/spi_phase_timer.sv
// ============================================================================
// Module   : spi_phase_timer
// Loadable down-counter; expired is high in the last cycle of a loaded phase.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Loading N gives a phase of N+1 cycles; the counter parks at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/spi_cmd_master.sv
// ============================================================================
// Module   : spi_cmd_master
// Shifts {opcode, A, B} to an SPI execution slave and returns its 32-bit result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_cmd_master
  import spi_proc_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter int REG_WIDTH  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OPCODE_W-1:0]  cmd_opcode,
  input  logic [REG_WIDTH-1:0] cmd_a,
  input  logic [REG_WIDTH-1:0] cmd_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [REG_WIDTH-1:0] rsp_data,
  output logic                 busy,
  spi_if.MASTER                spi
);

  localparam int FRAME_W  = OPCODE_W + 2 * REG_WIDTH;
  localparam int TX_CNT_W = $clog2(FRAME_W + 1);
  localparam int RX_CNT_W = $clog2(REG_WIDTH + 1);

  localparam logic [TX_CNT_W-1:0] LAST_TX   = TX_CNT_W'(FRAME_W - 1);
  localparam logic [RX_CNT_W-1:0] LAST_RX   = RX_CNT_W'(REG_WIDTH - 1);
  localparam logic [3:0]          GAP_LOAD  = 4'(GAP_CYCLES - 1);
  localparam logic [3:0]          TURN_LOAD = 4'(TURNAROUND_CYCLES - 1);

  spi_master_state_t      state_q,     state_d;
  logic [FRAME_W-1:0]     frame_q,     frame_d;
  logic [TX_CNT_W-1:0]    tx_cnt_q,    tx_cnt_d;
  logic [RX_CNT_W-1:0]    rx_cnt_q,    rx_cnt_d;
  logic [REG_WIDTH-2:0]   rx_shift_q,  rx_shift_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [REG_WIDTH-1:0]   rsp_data_q,  rsp_data_d;
  logic                   nss_q,       nss_d;
  logic                   sclk_q,      sclk_d;
  logic                   mosi_q,      mosi_d;

  logic                   timer_load;
  logic [3:0]             timer_value;
  logic                   timer_expired;

  spi_phase_timer #(
    .CNT_W (4)
  ) u_phase_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  assign cmd_ready = (state_q == ST_IDLE) && !rsp_valid_q;

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    rx_shift_d  = rx_shift_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          frame_d  = {cmd_opcode, cmd_a, cmd_b};
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          state_d  = ST_TX_LOW;
        end
      end
      ST_TX_LOW: begin
        if (timer_expired) begin
          state_d = ST_TX_HIGH;
        end
      end
      ST_TX_HIGH: begin
        frame_d  = {frame_q[FRAME_W-2:0], 1'b0};
        tx_cnt_d = tx_cnt_q + 1'b1;
        state_d  = (tx_cnt_q == LAST_TX) ? ST_TURN : ST_TX_LOW;
      end
      ST_TURN: begin
        if (timer_expired) begin
          state_d = ST_RX_LOW;
        end
      end
      ST_RX_LOW: begin
        // The slave advances miso on this same edge, so the pre-edge bit is taken.
        rx_shift_d = {rx_shift_q[REG_WIDTH-3:0], spi.miso};
        rx_cnt_d   = rx_cnt_q + 1'b1;
        if (rx_cnt_q == LAST_RX) begin
          rsp_data_d  = {rx_shift_q, spi.miso};
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          state_d = ST_RX_HIGH;
        end
      end
      ST_RX_HIGH: begin
        if (timer_expired) begin
          state_d = ST_RX_LOW;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    timer_load  = (state_d != state_q);
    timer_value = (state_d == ST_TURN) ? TURN_LOAD : GAP_LOAD;

    // Pins are registered from the next state so they change cleanly with it.
    nss_d  = (state_d == ST_IDLE) || (state_d == ST_RESP);
    sclk_d = (state_d == ST_TX_HIGH) || (state_d == ST_TURN) || (state_d == ST_RX_HIGH);
    mosi_d = ((state_d == ST_TX_LOW) || (state_d == ST_TX_HIGH)) ? frame_d[FRAME_W-1] : 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      rx_shift_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      nss_q       <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      nss_q       <= nss_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = !nss_q;
  assign spi.nss   = nss_q;
  assign spi.sclk  = sclk_q;
  assign spi.mosi  = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_master.sv
// ============================================================================
// Module   : tb_spi_cmd_master
// Directed bench: two masters (GAP_CYCLES 1 and 3), each with a level-counting shifter slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_cmd_master;
  import spi_proc_pkg::*;

  logic        clock;
  logic        reset;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [3:0]  cmd_opcode;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        busy      [2];

  int errors;
  int checks;
  int lat;

  spi_if spi_bus [2] ();

  initial clock = 1'b0;
  always #5 clock = ~clock;

  spi_cmd_master #(.GAP_CYCLES(1), .REG_WIDTH(32)) u_dut0 (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .busy(busy[0]), .spi(spi_bus[0])
  );

  spi_cmd_master #(.GAP_CYCLES(3), .REG_WIDTH(32)) u_dut1 (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .busy(busy[1]), .spi(spi_bus[1])
  );

  function automatic logic [31:0] slave_exec(input logic [67:0] f);
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    op = f[67:64];
    a  = f[63:32];
    b  = f[31:0];
    case (op)
      OP_SHL:  slave_exec = a << b[4:0];
      OP_SHR:  slave_exec = a >> b[4:0];
      OP_SAR:  slave_exec = $signed(a) >>> b[4:0];
      default: slave_exec = a + b;
    endcase
  endfunction

  // Slave: samples mosi on every sclk-high clock, then EXECUTE, LOAD, and
  // shifts on every sclk-low clock. Wrong pulse widths corrupt the result.
  for (genvar k = 0; k < 2; k++) begin : g_slave
    logic [67:0] sframe = '0;
    logic [31:0] sres   = '0;
    logic [31:0] ssh    = '0;
    int          scnt   = 0;
    int          sst    = 0;

    assign spi_bus[k].miso = ssh[31];

    always @(posedge clock) begin
      if (spi_bus[k].nss) begin
        sst  <= 0;
        scnt <= 0;
      end else begin
        case (sst)
          0: if (spi_bus[k].sclk) begin
               sframe <= {sframe[66:0], spi_bus[k].mosi};
               scnt   <= scnt + 1;
               if (scnt == FRAME_BITS - 1) sst <= 1;
             end
          1: begin sres <= slave_exec(sframe); sst <= 2; end
          2: begin ssh <= sres; sst <= 3; end
          default: if (!spi_bus[k].sclk) ssh <= {ssh[30:0], 1'b0};
        endcase
      end
    end
  end

  // Pulse monitor on pre-edge values: frame length, TX high / RX low run widths, inter-frame gap.
  for (genvar k = 0; k < 2; k++) begin : g_mon
    int frame_len = 0;
    int hi_idx    = 0;
    int hi_len    = 0;
    int lo_len    = 0;
    int tx_bad    = 0;
    int rx_bad    = 0;
    int rx_lows   = 0;
    int gap       = 0;
    int last_gap  = 0;
    bit in_frame  = 1'b0;

    always @(posedge clock) begin
      if (!spi_bus[k].nss) begin
        if (!in_frame) begin
          in_frame = 1'b1; frame_len = 0; hi_idx = 0; hi_len = 0; lo_len = 0;
          tx_bad = 0; rx_bad = 0; rx_lows = 0; last_gap = gap;
        end
        frame_len++;
        if (spi_bus[k].sclk) begin
          if (lo_len > 0) begin
            if (hi_idx >= FRAME_BITS) begin
              if (lo_len != 1) rx_bad++;
              rx_lows++;
            end
            lo_len = 0;
          end
          hi_len++;
        end else begin
          if (hi_len > 0) begin
            if (hi_idx < FRAME_BITS - 1 && hi_len != 1) tx_bad++;
            hi_idx++;
            hi_len = 0;
          end
          lo_len++;
        end
      end else begin
        if (in_frame) begin
          if (hi_len > 0) begin
            if (hi_idx < FRAME_BITS - 1 && hi_len != 1) tx_bad++;
            hi_idx++;
            hi_len = 0;
          end
          if (lo_len > 0) begin
            if (hi_idx >= FRAME_BITS) begin
              if (lo_len != 1) rx_bad++;
              rx_lows++;
            end
            lo_len = 0;
          end
          in_frame = 1'b0;
          gap      = 0;
        end
        gap++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_cmd(input int d, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    cmd_opcode   = op;
    cmd_a        = a;
    cmd_b        = b;
    cmd_valid[d] = 1'b1;
    while (cmd_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("cmd_accept_wait", 64'(n < 50), 64'd1);
    @(negedge clock);
    cmd_valid[d] = 1'b0;
    cmd_opcode   = 4'hF;
    cmd_a        = 32'hDEAD_BEEF;
    cmd_b        = 32'h1234_5678;
  endtask

  // Edges counted inclusive of the accept edge through the edge that raises rsp_valid.
  task automatic wait_rsp(input int d, output int edges);
    edges = 1;
    while (rsp_valid[d] !== 1'b1 && edges < 2000) begin
      @(negedge clock);
      edges++;
    end
  endtask

  task automatic take_rsp(input int d);
    rsp_ready[d] = 1'b1;
    @(negedge clock);
    rsp_ready[d] = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    cmd_valid[0] = 1'b0; cmd_valid[1] = 1'b0;
    rsp_ready[0] = 1'b0; rsp_ready[1] = 1'b0;
    cmd_opcode = '0; cmd_a = '0; cmd_b = '0;

    repeat (2) @(negedge clock);
    check("reset_pins", {spi_bus[0].nss, spi_bus[0].sclk, spi_bus[0].mosi}, 3'b100);
    check("reset_handshake", {cmd_ready[0], rsp_valid[0], busy[0]}, 3'b100);
    check("reset_rsp_data", rsp_data[0], 32'h0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_reset", {spi_bus[1].nss, spi_bus[1].sclk, cmd_ready[1], rsp_valid[1], busy[1]}, 5'b10100);

    // Abort a frame in the TX_HIGH of bit 20 (cycle 42 after accept)
    start_cmd(0, OP_SHL, 32'h0000_0001, 32'd4);
    repeat (41) @(negedge clock);
    check("pre_reset_tx_high", {busy[0], spi_bus[0].sclk}, 2'b11);
    reset = 1'b1;
    #1;
    check("async_reset_pins", {spi_bus[0].nss, spi_bus[0].sclk, busy[0]}, 3'b100);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    start_cmd(0, OP_SHL, 32'h0000_0001, 32'd4);
    wait_rsp(0, lat);
    check("shl_data", rsp_data[0], 32'h0000_0010);
    check("shl_latency", 64'(lat), 64'd202);
    take_rsp(0);
    check("shl_nss_low_cycles", 64'(g_mon[0].frame_len), 64'd201);
    check("shl_tx_high_width", 64'(g_mon[0].tx_bad), 64'd0);
    check("shl_rx_low_count", 64'(g_mon[0].rx_lows), 64'd32);
    check("rsp_consumed", {rsp_valid[0], cmd_ready[0]}, 2'b01);

    start_cmd(0, OP_SAR, 32'h8000_0000, 32'd31);
    wait_rsp(0, lat);
    check("sar_data", rsp_data[0], 32'hFFFF_FFFF);
    take_rsp(0);

    start_cmd(0, OP_SHR, 32'hF000_0000, 32'd36);
    wait_rsp(0, lat);
    check("shr_oversize_data", rsp_data[0], 32'h0F00_0000);

    // Back-pressure with a new command already offered
    cmd_opcode   = OP_SHL;
    cmd_a        = 32'hA5A5_A5A5;
    cmd_b        = 32'd8;
    cmd_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("backpressure_hold", {rsp_valid[0], cmd_ready[0], busy[0], rsp_data[0]}, {3'b100, 32'h0F00_0000});
    end
    rsp_ready[0] = 1'b1;
    @(negedge clock);
    rsp_ready[0] = 1'b0;
    check("resp_edge_no_accept", {rsp_valid[0], cmd_ready[0], busy[0]}, 3'b010);
    @(negedge clock);
    cmd_valid[0] = 1'b0;
    check("b2b_accepted", {busy[0], cmd_ready[0]}, 2'b10);
    wait_rsp(0, lat);
    check("b2b_shl_data", rsp_data[0], 32'hA5A5_A500);
    check("b2b_latency", 64'(lat), 64'd202);
    check("interframe_nss_high", 64'(g_mon[0].last_gap >= 1), 64'd1);
    take_rsp(0);
    check("b2b_rx_low_width", 64'(g_mon[0].rx_bad), 64'd0);

    // GAP_CYCLES=3 instance: 68*4 + 2 + 32 + 31*3 = 399 cycles with nss low
    start_cmd(1, OP_SHR, 32'h8000_0000, 32'd1);
    wait_rsp(1, lat);
    check("gap3_shr_data", rsp_data[1], 32'h4000_0000);
    check("gap3_latency", 64'(lat), 64'd400);
    take_rsp(1);
    check("gap3_nss_low_cycles", 64'(g_mon[1].frame_len), 64'd399);
    check("gap3_rx_low_width", 64'(g_mon[1].rx_bad), 64'd0);
    check("gap3_rx_low_count", 64'(g_mon[1].rx_lows), 64'd32);
    check("gap3_tx_high_width", 64'(g_mon[1].tx_bad), 64'd0);
    check("gap3_idle", {spi_bus[1].nss, spi_bus[1].sclk, spi_bus[1].mosi, cmd_ready[1]}, 4'b1001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
